// File: rtl/mac_pkg.sv
// Shared types and helpers for the vector MAC: FSM encoding, drain length
// and the signed saturation bounds used by every lane's requantiser.
package mac_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ACCUM = 3'd1,
    ST_DRAIN = 3'd2,
    ST_POST  = 3'd3,
    ST_OUT   = 3'd4
  } state_t;

  localparam int DRAIN_CYCLES = 2;

  function automatic longint sat_max(input int ow);
    return (64'sd1 <<< (ow - 1)) - 64'sd1;
  endfunction

  function automatic longint sat_min(input int ow);
    return -(64'sd1 <<< (ow - 1));
  endfunction

endpackage

// File: rtl/mac_lane.sv
// One MAC lane: operand register, product register, wrapping accumulator and
// the registered requantiser (ReLU, rounded arithmetic shift, saturation).
module mac_lane
  import mac_pkg::*;
#(
  parameter int DW = 8,
  parameter int AW = 32,
  parameter int OW = 8
) (
  input  logic                 clk_i,
  input  logic                 rstn_i,
  input  logic                 clr_i,
  input  logic                 beat_i,
  input  logic                 post_i,
  input  logic                 relu_i,
  input  logic [4:0]           shift_i,
  input  logic signed [DW-1:0] image_i,
  input  logic signed [DW-1:0] weight_i,
  output logic signed [OW-1:0] res_o
);

  localparam int XW = AW + 1;
  localparam logic signed [XW-1:0] SAT_HI = XW'(sat_max(OW));
  localparam logic signed [XW-1:0] SAT_LO = XW'(sat_min(OW));
  localparam logic signed [XW-1:0] ONE_X  = {{(XW-1){1'b0}}, 1'b1};

  logic signed [DW-1:0]   r_img;
  logic signed [DW-1:0]   r_wgt;
  logic                   r_op_vld;
  logic signed [2*DW-1:0] r_prod;
  logic                   r_prod_vld;
  logic signed [AW-1:0]   r_acc;
  logic signed [OW-1:0]   r_res;

  logic signed [AW-1:0]   w_prod_ext;
  logic signed [XW-1:0]   w_v;
  logic signed [XW-1:0]   w_rnd;
  logic signed [XW-1:0]   w_sh;
  logic signed [OW-1:0]   w_sat;

  assign w_prod_ext = {{(AW-2*DW){r_prod[2*DW-1]}}, r_prod};

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_img      <= '0;
      r_wgt      <= '0;
      r_op_vld   <= 1'b0;
      r_prod     <= '0;
      r_prod_vld <= 1'b0;
    end else begin
      r_op_vld   <= beat_i;
      r_prod_vld <= r_op_vld;
      if (beat_i) begin
        r_img <= image_i;
        r_wgt <= weight_i;
      end
      if (r_op_vld) begin
        r_prod <= r_img * r_wgt;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_acc <= '0;
    end else if (clr_i) begin
      r_acc <= '0;
    end else if (r_prod_vld) begin
      r_acc <= r_acc + w_prod_ext;
    end
  end

  // One extra bit of headroom keeps the rounding add from wrapping.
  always_comb begin
    w_v   = (relu_i && r_acc[AW-1]) ? '0 : {r_acc[AW-1], r_acc};
    w_rnd = w_v;
    w_sh  = w_v;
    if (shift_i != 5'd0) begin
      w_rnd = w_v + (ONE_X <<< (shift_i - 5'd1));
      w_sh  = w_rnd >>> shift_i;
    end else begin
      w_rnd = w_v;
      w_sh  = w_v;
    end
    if (w_sh > SAT_HI) begin
      w_sat = SAT_HI[OW-1:0];
    end else if (w_sh < SAT_LO) begin
      w_sat = SAT_LO[OW-1:0];
    end else begin
      w_sat = w_sh[OW-1:0];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_res <= '0;
    end else if (post_i) begin
      r_res <= w_sat;
    end
  end

  assign res_o = r_res;

endmodule

// File: rtl/mac_vector.sv
// LANES-wide dot-product engine: one broadcast image stream, per-lane weights,
// sequenced by an IDLE/ACCUM/DRAIN/POST/OUT controller.
module mac_vector
  import mac_pkg::*;
#(
  parameter int LANES = 4,
  parameter int DW    = 8,
  parameter int AW    = 32,
  parameter int OW    = 8,
  parameter int LEN_W = 10
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic                  start_i,
  input  logic [LEN_W-1:0]      len_i,
  input  logic                  relu_en_i,
  input  logic [4:0]            shift_i,
  input  logic                  in_valid_i,
  output logic                  in_ready_o,
  input  logic [DW-1:0]         image_i,
  input  logic [LANES*DW-1:0]   weight_i,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [LANES*OW-1:0]   out_data_o,
  output logic                  busy_o
);

  localparam int DRW = $clog2(DRAIN_CYCLES + 1);
  localparam logic [LEN_W-1:0] CNT_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
  localparam logic [DRW-1:0]   DRW_ONE  = {{(DRW-1){1'b0}}, 1'b1};
  localparam logic [DRW-1:0]   DRW_LAST = DRW'(DRAIN_CYCLES - 1);

  if (AW < 2*DW + LEN_W) begin : g_aw_check
    $error("mac_vector: AW too small for 2*DW+LEN_W");
  end

  state_t           r_state;
  state_t           w_state_nxt;
  logic [LEN_W-1:0] r_cnt;
  logic [LEN_W-1:0] r_len;
  logic             r_relu;
  logic [4:0]       r_shift;
  logic [DRW-1:0]   r_drain;

  logic             w_start_acc;
  logic             w_xfer;
  logic [LEN_W-1:0] w_cnt_inc;
  logic [OW-1:0]    w_res [LANES];

  assign w_start_acc = (r_state == ST_IDLE) && start_i;
  assign w_xfer      = (r_state == ST_ACCUM) && in_valid_i;
  assign w_cnt_inc   = r_cnt + CNT_ONE;

  assign in_ready_o  = (r_state == ST_ACCUM);
  assign out_valid_o = (r_state == ST_OUT);
  assign busy_o      = (r_state != ST_IDLE);

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start_i) begin
          w_state_nxt = (len_i != '0) ? ST_ACCUM : ST_DRAIN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_ACCUM: begin
        if (w_xfer && (w_cnt_inc == r_len)) begin
          w_state_nxt = ST_DRAIN;
        end else begin
          w_state_nxt = ST_ACCUM;
        end
      end
      ST_DRAIN: begin
        if (r_drain == DRW_LAST) begin
          w_state_nxt = ST_POST;
        end else begin
          w_state_nxt = ST_DRAIN;
        end
      end
      ST_POST: w_state_nxt = ST_OUT;
      ST_OUT: begin
        if (out_ready_i) begin
          w_state_nxt = ST_IDLE;
        end else begin
          w_state_nxt = ST_OUT;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Operation context is captured once so later input changes are ignored.
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_cnt   <= '0;
      r_len   <= '0;
      r_relu  <= 1'b0;
      r_shift <= 5'd0;
    end else if (w_start_acc) begin
      r_cnt   <= '0;
      r_len   <= len_i;
      r_relu  <= relu_en_i;
      r_shift <= shift_i;
    end else if (w_xfer) begin
      r_cnt   <= w_cnt_inc;
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      r_drain <= '0;
    end else if (r_state == ST_DRAIN) begin
      r_drain <= r_drain + DRW_ONE;
    end else begin
      r_drain <= '0;
    end
  end

  for (genvar k = 0; k < LANES; k++) begin : g_lane
    mac_lane #(
      .DW (DW),
      .AW (AW),
      .OW (OW)
    ) u_lane (
      .clk_i    (clk_i),
      .rstn_i   (rstn_i),
      .clr_i    (w_start_acc),
      .beat_i   (w_xfer),
      .post_i   (r_state == ST_POST),
      .relu_i   (r_relu),
      .shift_i  (r_shift),
      .image_i  (image_i),
      .weight_i (weight_i[k*DW +: DW]),
      .res_o    (w_res[k])
    );
    assign out_data_o[k*OW +: OW] = w_res[k];
  end

endmodule

// File: tb/tb_mac_vector.sv
// Directed and randomized checks of mac_vector against a plain-arithmetic
// dot-product / requantisation reference model.
module tb_mac_vector;

  localparam int LANES = 4;
  localparam int DW    = 8;
  localparam int AW    = 32;
  localparam int OW    = 8;
  localparam int LEN_W = 10;

  logic                 clk_i = 1'b0;
  logic                 rstn_i;
  logic                 start_i;
  logic [LEN_W-1:0]     len_i;
  logic                 relu_en_i;
  logic [4:0]           shift_i;
  logic                 in_valid_i;
  logic                 in_ready_o;
  logic [DW-1:0]        image_i;
  logic [LANES*DW-1:0]  weight_i;
  logic                 out_valid_o;
  logic                 out_ready_i;
  logic [LANES*OW-1:0]  out_data_o;
  logic                 busy_o;

  int total = 0;
  int bad   = 0;
  int img_a [16];
  int wgt_a [16][LANES];
  logic [LANES*OW-1:0] obs_vec;

  mac_vector #(
    .LANES (LANES), .DW (DW), .AW (AW), .OW (OW), .LEN_W (LEN_W)
  ) dut (
    .clk_i       (clk_i),
    .rstn_i      (rstn_i),
    .start_i     (start_i),
    .len_i       (len_i),
    .relu_en_i   (relu_en_i),
    .shift_i     (shift_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .image_i     (image_i),
    .weight_i    (weight_i),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .out_data_o  (out_data_o),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic chk(input string tag, input logic signed [63:0] obs, input logic signed [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic logic signed [63:0] lane_of(input logic [LANES*OW-1:0] v, input int k);
    logic signed [OW-1:0] t;
    t = v[k*OW +: OW];
    return t;
  endfunction

  // Reference: exact dot product, then ReLU, round-half-up shift, clamp.
  function automatic logic [LANES*OW-1:0] ref_vec(input int len, input bit relu, input int sh);
    logic [LANES*OW-1:0] r;
    longint acc;
    longint v;
    r = '0;
    for (int k = 0; k < LANES; k++) begin
      acc = 0;
      for (int b = 0; b < len; b++) acc += longint'(img_a[b] * wgt_a[b][k]);
      v = (relu && acc < 0) ? 0 : acc;
      if (sh > 0) v = (v + (longint'(1) << (sh - 1))) >>> sh;
      if (v > 127) v = 127;
      if (v < -128) v = -128;
      r[k*OW +: OW] = OW'(v);
    end
    return r;
  endfunction

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic fill_random(input int len);
    for (int b = 0; b < len; b++) begin
      img_a[b] = int'($urandom_range(0, 255)) - 128;
      for (int k = 0; k < LANES; k++) wgt_a[b][k] = int'($urandom_range(0, 255)) - 128;
    end
  endtask

  task automatic drive_beat(input int b);
    image_i = DW'(img_a[b]);
    for (int k = 0; k < LANES; k++) weight_i[k*DW +: DW] = DW'(wgt_a[b][k]);
  endtask

  task automatic run_op(input int len, input bit relu, input int sh, input int stall_at,
                        input int stall_len, input int hold, input bit busy_start,
                        input bit hs_start, input string tag);
    logic [LANES*OW-1:0] exp_v;
    int n;
    exp_v = ref_vec(len, relu, sh);
    start_i = 1'b1; len_i = LEN_W'(len); relu_en_i = relu; shift_i = 5'(sh);
    tick();
    start_i = 1'b0;
    len_i = LEN_W'($urandom); relu_en_i = 1'($urandom); shift_i = 5'($urandom);
    chk({tag, "_busy"}, busy_o, 1);
    chk({tag, "_ready_at_start"}, in_ready_o, (len > 0) ? 1 : 0);
    for (int b = 0; b < len; b++) begin
      if (b == stall_at) begin
        in_valid_i = 1'b0;
        image_i = DW'($urandom); weight_i = LANES*DW'($urandom);
        for (int s = 0; s < stall_len; s++) begin
          start_i = busy_start && (s == 0);
          len_i = LEN_W'(1);
          tick();
          start_i = 1'b0;
        end
        chk({tag, "_stall_ready"}, in_ready_o, 1);
      end
      in_valid_i = 1'b1;
      drive_beat(b);
      n = 0;
      while (!in_ready_o && n < 50) begin tick(); n++; end
      chk({tag, "_ready_wait"}, n, 0);
      tick();
    end
    in_valid_i = 1'b0;
    // The final beat (or the start, for len=0) is edge 1; out_valid rises on edge 4.
    chk({tag, "_lat_e1"}, out_valid_o, 0);
    tick();
    chk({tag, "_lat_e2"}, out_valid_o, 0);
    chk({tag, "_no_ready"}, in_ready_o, 0);
    tick();
    chk({tag, "_lat_e3"}, out_valid_o, 0);
    tick();
    chk({tag, "_lat_e4"}, out_valid_o, 1);
    obs_vec = out_data_o;
    chk({tag, "_data"}, out_data_o, exp_v);
    out_ready_i = 1'b0;
    for (int h = 0; h < hold; h++) begin
      start_i = busy_start && (h == 0);
      tick();
      start_i = 1'b0;
      chk({tag, "_hold_valid"}, out_valid_o, 1);
      chk({tag, "_hold_data"}, out_data_o, exp_v);
    end
    out_ready_i = 1'b1;
    start_i = hs_start;
    len_i = LEN_W'(1);
    tick();
    out_ready_i = 1'b0;
    start_i = 1'b0;
    chk({tag, "_idle_after_hs"}, busy_o, 0);
    chk({tag, "_valid_after_hs"}, out_valid_o, 0);
  endtask

  initial begin
    rstn_i = 1'b0; start_i = 1'b0; len_i = '0; relu_en_i = 1'b0; shift_i = 5'd0;
    in_valid_i = 1'b0; image_i = '0; weight_i = '0; out_ready_i = 1'b0;
    #12;
    chk("rst_ready", in_ready_o, 0);
    chk("rst_valid", out_valid_o, 0);
    chk("rst_busy", busy_o, 0);
    chk("rst_data", out_data_o, 0);
    rstn_i = 1'b1;
    tick();

    // Single beat 3 * -4 on lane 0.
    img_a[0] = 3; wgt_a[0][0] = -4;
    for (int k = 1; k < LANES; k++) wgt_a[0][k] = int'($urandom_range(0, 255)) - 128;
    run_op(1, 1'b0, 0, -1, 0, 0, 1'b0, 1'b0, "single");
    chk("single_lane0", lane_of(obs_vec, 0), -12);

    run_op(1, 1'b1, 0, -1, 0, 0, 1'b0, 1'b0, "relu");
    chk("relu_lane0", lane_of(obs_vec, 0), 0);

    for (int b = 0; b < 4; b++) begin
      img_a[b] = 127;
      for (int k = 0; k < LANES; k++) wgt_a[b][k] = 127;
    end
    run_op(4, 1'b0, 7, -1, 0, 0, 1'b0, 1'b0, "sat");
    chk("sat_all", obs_vec, {LANES{8'sd127}});

    fill_random(3);
    run_op(3, 1'b0, 0, 1, 5, 10, 1'b1, 1'b1, "stall_hold");

    run_op(0, 1'b0, 0, -1, 0, 0, 1'b0, 1'b0, "len0");
    chk("len0_zero", obs_vec, 0);

    // Abort after two of four beats, then a clean single-beat run.
    fill_random(4);
    start_i = 1'b1; len_i = LEN_W'(4); relu_en_i = 1'b0; shift_i = 5'd0;
    tick();
    start_i = 1'b0;
    in_valid_i = 1'b1;
    drive_beat(0);
    tick();
    drive_beat(1);
    tick();
    in_valid_i = 1'b0;
    #2 rstn_i = 1'b0;
    #1;
    chk("abort_ready", in_ready_o, 0);
    chk("abort_valid", out_valid_o, 0);
    chk("abort_busy", busy_o, 0);
    chk("abort_data", out_data_o, 0);
    tick();
    rstn_i = 1'b1;
    tick();
    fill_random(1);
    run_op(1, 1'b0, 0, -1, 0, 0, 1'b0, 1'b0, "after_abort");

    for (int r = 0; r < 6; r++) begin
      int len;
      len = int'($urandom_range(1, 8));
      fill_random(len);
      run_op(len, 1'($urandom_range(0, 1)), int'($urandom_range(0, 12)),
             int'($urandom_range(0, 8)), int'($urandom_range(1, 3)),
             int'($urandom_range(0, 3)), 1'b1, 1'($urandom_range(0, 1)), "rand");
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
